// File: rtl/ingress_inject_pkg.sv
// Shared types and constants for the per-ingress injection controller.
// Credit is scaled so that RATE_SCALE units equal one flit.
package ingress_inject_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  localparam int RATE_SCALE = 100;
  localparam int CREDIT_MAX = 200;
  localparam int PAYLOAD_W  = 64;
  localparam int TAG_W      = 16;

endpackage

// File: rtl/ingress_rate_limiter.sv
// Credit accumulator: adds INJECTION_RATE per accrue cycle (cap CREDIT_MAX),
// removes one flit worth on consume. Ports: clk, reset, accrue_i, consume_i, credit_ok_next_o.
module ingress_rate_limiter
  import ingress_inject_pkg::*;
#(
  parameter int INJECTION_RATE = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic accrue_i,
  input  logic consume_i,
  output logic credit_ok_next_o
);

  logic [7:0] credit_q, credit_d;
  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, credit_q};
    if (accrue_i) sum = sum + 9'(INJECTION_RATE);
    if (sum > 9'(CREDIT_MAX)) sum = 9'(CREDIT_MAX);
    if (consume_i) sum = sum - 9'(RATE_SCALE);
    credit_d = sum[7:0];
  end

  assign credit_ok_next_o = credit_d >= 8'(RATE_SCALE);

  always_ff @(posedge clk) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

endmodule

// File: rtl/ingress_inject_ctrl.sv
// Per-ingress flit scheduler: rate-gated injection, head/tail framing,
// rotating egress, {tag,seq} payload, done after NUM_FLITS fires.
// Ports: clk, reset, enable, flit_out_{valid,ready,head,tail,egress_id,payload},
// flits_sent, done.
module ingress_inject_ctrl
  import ingress_inject_pkg::*;
#(
  parameter int NUM_EGRESSES   = 4,
  parameter int INGRESS_ID     = 0,
  parameter int INJECTION_RATE = 100,
  parameter int NUM_FLITS      = 64,
  parameter int PKT_FLITS      = 4,
  parameter int EGRESS_W       = (NUM_EGRESSES > 1) ? $clog2(NUM_EGRESSES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 flit_out_valid,
  input  logic                 flit_out_ready,
  output logic                 flit_out_head,
  output logic                 flit_out_tail,
  output logic [EGRESS_W-1:0]  flit_out_egress_id,
  output logic [PAYLOAD_W-1:0] flit_out_payload,
  output logic [31:0]          flits_sent,
  output logic                 done
);

  if (INJECTION_RATE < 0 || INJECTION_RATE > RATE_SCALE ||
      PKT_FLITS < 1 || NUM_EGRESSES < 1) begin : g_param_err
    $error("ingress_inject_ctrl: illegal parameter set");
  end

  localparam int PI_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [31:0] LAST_SEQ = 32'(NUM_FLITS - 1);
  localparam logic [PI_W-1:0] PI_LAST = PI_W'(PKT_FLITS - 1);
  localparam logic [EGRESS_W-1:0] EG_LAST = EGRESS_W'(NUM_EGRESSES - 1);
  localparam logic [EGRESS_W-1:0] EG_RST =
    EGRESS_W'(INGRESS_ID % NUM_EGRESSES);
  localparam bit NO_FLITS = (NUM_FLITS == 0);

  state_e state_q, state_d;
  logic [31:0] seq_q;
  logic [PI_W-1:0] idx_q;
  logic [EGRESS_W-1:0] egr_q;
  logic accrue, fire, ok_next, last, tail_raw;

  assign fire     = (state_q == S_SEND) && flit_out_ready;
  assign last     = (seq_q == LAST_SEQ);
  assign tail_raw = (idx_q == PI_LAST) || last;

  ingress_rate_limiter #(
    .INJECTION_RATE(INJECTION_RATE)
  ) u_rate (
    .clk              (clk),
    .reset            (reset),
    .accrue_i         (accrue),
    .consume_i        (fire),
    .credit_ok_next_o (ok_next)
  );

  always_comb begin
    state_d = state_q;
    accrue  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (NO_FLITS)    state_d = S_DONE;
        else if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        accrue = enable;
        if (!enable)      state_d = S_IDLE;
        else if (ok_next) state_d = S_SEND;
      end
      S_SEND: begin
        // valid is never retracted, so credit keeps accruing while stalled
        accrue = 1'b1;
        if (fire) begin
          if (last)          state_d = S_DONE;
          else if (!enable)  state_d = S_IDLE;
          else if (!ok_next) state_d = S_WAIT;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      idx_q   <= '0;
      egr_q   <= EG_RST;
    end else begin
      state_q <= state_d;
      if (fire) begin
        seq_q <= seq_q + 32'd1;
        if (tail_raw) begin
          idx_q <= '0;
          egr_q <= (egr_q == EG_LAST) ? '0 : egr_q + EGRESS_W'(1);
        end else begin
          idx_q <= idx_q + PI_W'(1);
        end
      end
    end
  end

  assign flit_out_valid     = (state_q == S_SEND);
  assign flit_out_head      = flit_out_valid && (idx_q == '0);
  assign flit_out_tail      = flit_out_valid && tail_raw;
  assign flit_out_egress_id = flit_out_valid ? egr_q : '0;
  assign flit_out_payload   = flit_out_valid ?
    {TAG_W'(INGRESS_ID), (PAYLOAD_W-TAG_W)'(seq_q)} : '0;
  assign flits_sent         = seq_q;
  assign done               = (state_q == S_DONE);

endmodule

// File: tb/tb_ingress_inject_ctrl.sv
// Bench for ingress_inject_ctrl: six parameter sets, a vector table,
// directed corner sequences and a randomized run against a flag-based model.
module tb_ingress_inject_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [6];
  logic en  [6];
  logic rdy [6];
  logic v   [6];
  logic h   [6];
  logic t   [6];
  logic dn  [6];
  logic [1:0]  eg [6];
  logic [63:0] pl [6];
  logic [31:0] fs [6];

  int nvec = 0;
  int nbad = 0;

  ingress_inject_ctrl #(.NUM_EGRESSES(4), .INGRESS_ID(1), .INJECTION_RATE(100),
    .NUM_FLITS(8), .PKT_FLITS(4)) u0 (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .flit_out_valid(v[0]),
    .flit_out_ready(rdy[0]), .flit_out_head(h[0]), .flit_out_tail(t[0]),
    .flit_out_egress_id(eg[0]), .flit_out_payload(pl[0]),
    .flits_sent(fs[0]), .done(dn[0]));

  ingress_inject_ctrl #(.NUM_EGRESSES(4), .INGRESS_ID(0), .INJECTION_RATE(50),
    .NUM_FLITS(4), .PKT_FLITS(4)) u1 (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .flit_out_valid(v[1]),
    .flit_out_ready(rdy[1]), .flit_out_head(h[1]), .flit_out_tail(t[1]),
    .flit_out_egress_id(eg[1]), .flit_out_payload(pl[1]),
    .flits_sent(fs[1]), .done(dn[1]));

  ingress_inject_ctrl #(.NUM_EGRESSES(4), .INGRESS_ID(3), .INJECTION_RATE(100),
    .NUM_FLITS(6), .PKT_FLITS(4)) u2 (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .flit_out_valid(v[2]),
    .flit_out_ready(rdy[2]), .flit_out_head(h[2]), .flit_out_tail(t[2]),
    .flit_out_egress_id(eg[2]), .flit_out_payload(pl[2]),
    .flits_sent(fs[2]), .done(dn[2]));

  ingress_inject_ctrl #(.NUM_EGRESSES(3), .INGRESS_ID(2), .INJECTION_RATE(37),
    .NUM_FLITS(40), .PKT_FLITS(3)) u3 (
    .clk(clk), .reset(rst[3]), .enable(en[3]), .flit_out_valid(v[3]),
    .flit_out_ready(rdy[3]), .flit_out_head(h[3]), .flit_out_tail(t[3]),
    .flit_out_egress_id(eg[3]), .flit_out_payload(pl[3]),
    .flits_sent(fs[3]), .done(dn[3]));

  ingress_inject_ctrl #(.NUM_EGRESSES(4), .INGRESS_ID(0), .INJECTION_RATE(0),
    .NUM_FLITS(5), .PKT_FLITS(2)) u4 (
    .clk(clk), .reset(rst[4]), .enable(en[4]), .flit_out_valid(v[4]),
    .flit_out_ready(rdy[4]), .flit_out_head(h[4]), .flit_out_tail(t[4]),
    .flit_out_egress_id(eg[4]), .flit_out_payload(pl[4]),
    .flits_sent(fs[4]), .done(dn[4]));

  ingress_inject_ctrl #(.NUM_EGRESSES(4), .INGRESS_ID(2), .INJECTION_RATE(100),
    .NUM_FLITS(0), .PKT_FLITS(4)) u5 (
    .clk(clk), .reset(rst[5]), .enable(en[5]), .flit_out_valid(v[5]),
    .flit_out_ready(rdy[5]), .flit_out_head(h[5]), .flit_out_tail(t[5]),
    .flit_out_egress_id(eg[5]), .flit_out_payload(pl[5]),
    .flits_sent(fs[5]), .done(dn[5]));

  // Reference model: a flit is "on offer" once enough credit has built up
  // while enabled; fields of the presented flit follow from the sent count.
  typedef struct {
    int rate, nf, pk, id, ne;
    int credit, sent;
    bit armed, offer, fin;
  } mdl_t;
  mdl_t m [6];

  typedef struct {
    bit en, rdy, v, h, t;
    int eg, sent;
    bit dn;
  } vec_t;
  vec_t tbl [12];

  function automatic vec_t mk(bit e, bit r, bit ev, bit eh, bit et,
                              int ee, int es, bit ed);
    vec_t x;
    x.en = e; x.rdy = r; x.v = ev; x.h = eh; x.t = et;
    x.eg = ee; x.sent = es; x.dn = ed;
    return x;
  endfunction

  task automatic cmp(input string nm, input int k,
                     input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", nm, k, $time, got, exp);
    end
  endtask

  task automatic mcfg(input int k, input int r, input int nf, input int pk,
                      input int id, input int ne);
    m[k].rate = r; m[k].nf = nf; m[k].pk = pk; m[k].id = id; m[k].ne = ne;
  endtask

  task automatic mreset(input int k);
    m[k].credit = 0; m[k].sent = 0;
    m[k].armed = 0; m[k].offer = 0; m[k].fin = 0;
  endtask

  task automatic mstep(input int k, input bit e, input bit y);
    mdl_t s;
    s = m[k];
    if (s.fin) return;
    if (s.offer) begin
      s.credit = (s.credit + s.rate > 200) ? 200 : s.credit + s.rate;
      if (y) begin
        s.credit -= 100;
        s.sent++;
        if (s.sent == s.nf) begin
          s.fin = 1; s.offer = 0; s.armed = 0;
        end else if (!e) begin
          s.offer = 0; s.armed = 0;
        end else if (s.credit < 100) begin
          s.offer = 0;
        end
      end
    end else if (s.armed) begin
      if (!e) s.armed = 0;
      else begin
        s.credit = (s.credit + s.rate > 200) ? 200 : s.credit + s.rate;
        if (s.credit >= 100) s.offer = 1;
      end
    end else begin
      if (s.nf == 0) s.fin = 1;
      else if (e) s.armed = 1;
    end
    m[k] = s;
  endtask

  task automatic check(input int k);
    mdl_t s;
    int ix;
    s = m[k];
    ix = s.sent % s.pk;
    cmp("valid", k, v[k], s.offer);
    cmp("head", k, h[k], s.offer && ix == 0);
    cmp("tail", k, t[k], s.offer && (ix == s.pk - 1 || s.sent == s.nf - 1));
    cmp("egress", k, eg[k], s.offer ? (s.id + s.sent / s.pk) % s.ne : 0);
    cmp("payload", k, pl[k], s.offer ? {16'(s.id), 48'(s.sent)} : 64'd0);
    cmp("sent", k, fs[k], s.sent);
    cmp("done", k, dn[k], s.fin);
  endtask

  // Called at a negedge: drive inputs, check, advance model, next negedge.
  task automatic cyc(input int k, input bit r, input bit e, input bit y);
    rst[k] = r; en[k] = e; rdy[k] = y;
    check(k);
    if (r) mreset(k);
    else   mstep(k, e, y);
    @(negedge clk);
  endtask

  task automatic hreset(input int k);
    rst[k] = 1; en[k] = 0; rdy[k] = 0;
    @(negedge clk);
    mreset(k);
    rst[k] = 0;
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      rst[k] = 1; en[k] = 0; rdy[k] = 0;
      mreset(k);
    end
    mcfg(0, 100, 8, 4, 1, 4);
    mcfg(1, 50, 4, 4, 0, 4);
    mcfg(2, 100, 6, 4, 3, 4);
    mcfg(3, 37, 40, 3, 2, 3);
    mcfg(4, 0, 5, 2, 0, 4);
    mcfg(5, 100, 0, 4, 2, 4);

    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 1, 0, 1, 0, 0);
    tbl[3]  = mk(1, 1, 1, 0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 1, 2, 0);
    tbl[5]  = mk(1, 1, 1, 0, 1, 1, 3, 0);
    tbl[6]  = mk(1, 1, 1, 1, 0, 2, 4, 0);
    tbl[7]  = mk(1, 1, 1, 0, 0, 2, 5, 0);
    tbl[8]  = mk(1, 1, 1, 0, 0, 2, 6, 0);
    tbl[9]  = mk(1, 1, 1, 0, 1, 2, 7, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 8, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 8, 1);

    repeat (3) @(negedge clk);

    // table: rate 100, two 4-flit packets from ingress 1
    rst[0] = 0;
    for (int i = 0; i < 12; i++) begin
      en[0] = tbl[i].en; rdy[0] = tbl[i].rdy;
      cmp("tbl_valid", 0, v[0], tbl[i].v);
      cmp("tbl_head", 0, h[0], tbl[i].h);
      cmp("tbl_tail", 0, t[0], tbl[i].t);
      cmp("tbl_egress", 0, eg[0], tbl[i].eg);
      cmp("tbl_payload", 0, pl[0],
          tbl[i].v ? {16'd1, 48'(tbl[i].sent)} : 64'd0);
      cmp("tbl_sent", 0, fs[0], tbl[i].sent);
      cmp("tbl_done", 0, dn[0], tbl[i].dn);
      @(negedge clk);
    end

    // stall of 5 cycles mid-packet, then resume
    hreset(0);
    repeat (3) cyc(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cmp("stall_valid", 0, v[0], 1);
      cmp("stall_payload", 0, pl[0], {16'd1, 48'd1});
      cyc(0, 0, 1, 0);
    end
    repeat (9) cyc(0, 0, 1, 1);
    cmp("stall_done", 0, dn[0], 1);

    // enable dropped in SEND while stalled
    hreset(0);
    repeat (4) cyc(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cmp("endrop_hold", 0, v[0], 1);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1);
    cmp("endrop_idle", 0, v[0], 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cmp("resume_valid", 0, v[0], 1);
    cmp("resume_head", 0, h[0], 0);
    cmp("resume_tail", 0, t[0], 1);
    cmp("resume_payload", 0, pl[0], {16'd1, 48'd3});
    repeat (4) cyc(0, 0, 1, 1);

    // reset during flit 2 of a packet
    hreset(0);
    repeat (4) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    cmp("rst_valid", 0, v[0], 0);
    cmp("rst_payload", 0, pl[0], 64'd0);
    cmp("rst_sent", 0, fs[0], 0);
    repeat (2) cyc(0, 0, 1, 1);
    cmp("rst_head", 0, h[0], 1);
    cmp("rst_egress", 0, eg[0], 1);
    cmp("rst_seq", 0, pl[0], {16'd1, 48'd0});
    repeat (3) cyc(0, 0, 1, 1);

    // rate 50
    hreset(1);
    repeat (14) cyc(1, 0, 1, 1);
    cmp("r50_done", 1, dn[1], 1);
    cmp("r50_sent", 1, fs[1], 4);

    // truncated final packet, egress wrap 3 -> 0
    hreset(2);
    repeat (12) cyc(2, 0, 1, 1);
    cmp("trunc_done", 2, dn[2], 1);
    cmp("trunc_sent", 2, fs[2], 6);

    // rate 0 never injects
    hreset(4);
    repeat (30) cyc(4, 0, 1, 1);
    cmp("r0_valid", 4, v[4], 0);
    cmp("r0_done", 4, dn[4], 0);

    // zero flits finishes without enable
    hreset(5);
    repeat (3) cyc(5, 0, 0, 0);
    cmp("nf0_done", 5, dn[5], 1);

    // randomized enable/ready at rate 37
    hreset(3);
    for (int i = 0; i < 600; i++)
      cyc(3, 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
    for (int i = 0; i < 400 && !m[3].fin; i++) cyc(3, 0, 1, 1);
    cyc(3, 0, 1, 1);
    cmp("rand_done", 3, dn[3], 1);
    cmp("rand_sent", 3, fs[3], 40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
